multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: fetch/decode/exec/mem/wb sequencing.
// Strobes are combinational from state and the latched opcode class.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic [1:0]  imm_sel,
  output logic        alu_src_b,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R      = 3'd0,
    C_OPI    = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_JAL    = 3'd5,
    C_JALR   = 3'd6
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_OPI    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t st;
  cls_t   cls;

  assign state = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= FETCH;
      cls     <= C_R;
      illegal <= 1'b0;
      instret <= 32'd0;
    end else begin
      if (pc_write)
        instret <= instret + 32'd1;
      unique case (st)
        FETCH: begin
          if (mem_ready)
            st <= DECODE;
        end
        DECODE: begin
          st <= EXEC;
          unique case (instr[6:0])
            OP_R:      cls <= C_R;
            OP_OPI:    cls <= C_OPI;
            OP_LOAD:   cls <= C_LOAD;
            OP_STORE:  cls <= C_STORE;
            OP_BRANCH: cls <= C_BRANCH;
            OP_JAL:    cls <= C_JAL;
            OP_JALR:   cls <= C_JALR;
            default: begin
              st      <= TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        EXEC: begin
          unique case (cls)
            C_BRANCH:        st <= FETCH;
            C_LOAD, C_STORE: st <= MEM;
            default:         st <= WB;
          endcase
        end
        MEM: begin
          if (mem_ready)
            st <= (cls == C_STORE) ? FETCH : WB;
        end
        WB:      st <= FETCH;
        TRAP:    st <= TRAP;
        default: st <= FETCH;
      endcase
    end
  end

  // Datapath selects depend only on the class, not on the state.
  always_comb begin
    imm_sel   = 2'd0;
    alu_src_b = 1'b1;
    wb_sel    = 2'd0;
    unique case (cls)
      C_R:      alu_src_b = 1'b0;
      C_STORE:  imm_sel = 2'd1;
      C_BRANCH: begin
        imm_sel   = 2'd2;
        alu_src_b = 1'b0;
      end
      C_JAL: begin
        imm_sel = 2'd3;
        wb_sel  = 2'd2;
      end
      C_JALR:   wb_sel = 2'd2;
      C_LOAD:   wb_sel = 2'd1;
      default: ;
    endcase
  end

  // Reset gates every strobe so nothing escapes while it is held.
  always_comb begin
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    reg_write = 1'b0;
    if (!reset) begin
      unique case (st)
        FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        EXEC: begin
          if (cls == C_BRANCH) begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'd1 : 2'd0;
          end
        end
        MEM: begin
          mem_req  = 1'b1;
          mem_we   = (cls == C_STORE);
          pc_write = mem_ready && (cls == C_STORE);
        end
        WB: begin
          pc_write  = 1'b1;
          reg_write = |instr[11:7];
          unique case (cls)
            C_JAL:   pc_src = 2'd3 - 2'd1;
            C_JALR:  pc_src = 2'd3;
            default: pc_src = 2'd0;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
